nano_v_core: RTL and testbench

NANO_V_CORE -- requirements
Module: nanoV_core

---
 rtl/nano_v_core.sv | 210 +++++++++++++++++++++
 tb/tb_nano_v_core.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nano_v_core.sv
// nano_v_core: bit-serial RV32E execute core.
// One instruction per execute pass: 32 clocks with cycle=0 and counter stepping 0..31, one result
// bit per clock (LSB first). Operand bits are read straight out of the register file by index,
// so shifts complete in one pass. rd is written on the counter=31 clock only.
// Ports:
//   clk            sole clock, rising edge
//   rstn           synchronous reset, active HIGH (1 = reset)
//   next_instr     lookahead instruction bits, unused by the core
//   instr          current instruction, stable for the whole pass
//   cycle          phase: 0 = execute pass, 1-7 = idle
//   counter        bit index of the current clock
//   pc             serial PC bit[counter]
//   data_in        serial load data bit[counter]
//   shift_data_out shift data_out right during idle phases
//   shift_pc       PC shift-register advance request (high during execute)
//   data_out       result / store-data shift register
//   branch         registered taken-flow-change flag
module nano_v_core (
  input  logic        clk,
  input  logic        rstn,
  input  logic [30:0] next_instr,
  input  logic [31:0] instr,
  input  logic [2:0]  cycle,
  input  logic [4:0]  counter,
  input  logic        pc,
  input  logic        data_in,
  input  logic        shift_data_out,
  output logic        shift_pc,
  output logic [31:0] data_out,
  output logic        branch
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  logic [31:0] regs [16];
  logic [31:0] data_out_q, data_out_d;
  logic        branch_q, branch_d;
  logic        carry_q, carry_d;
  logic        eq_q, eq_d;

  logic unused_next_instr;
  assign unused_next_instr = ^next_instr;

  // Decode
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alt;
  logic [4:0]  rd;
  logic [3:0]  rs1_idx, rs2_idx;
  logic [31:0] rs1_val, rs2_val, imm_i, imm_u, op_b;
  logic        is_alu, is_sub, is_slt, writes_rd, last;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign alt     = instr[30];
  assign rd      = instr[11:7];
  assign rs1_idx = instr[18:15];
  assign rs2_idx = instr[23:20];
  assign rs1_val = (rs1_idx == 4'd0) ? 32'd0 : regs[rs1_idx];
  assign rs2_val = (rs2_idx == 4'd0) ? 32'd0 : regs[rs2_idx];
  assign imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign imm_u   = {instr[31:12], 12'd0};
  assign op_b    = (opcode == OpImm) ? imm_i : rs2_val;

  assign is_alu  = (opcode == OpReg) || (opcode == OpImm);
  assign is_slt  = is_alu && (funct3[2:1] == 2'b01);
  // Subtract (rs2/imm inverted, carry-in 1) for SUB, set-less-than and all conditional branches
  assign is_sub  = ((opcode == OpReg) && (funct3 == 3'b000) && alt) || is_slt ||
                   (opcode == OpBranch);
  assign writes_rd = is_alu || (opcode == OpLui) || (opcode == OpAuipc) || (opcode == OpJal) ||
                     (opcode == OpJalr) || (opcode == OpLoad);
  assign last    = (cycle == 3'd0) && (counter == 5'd31);

  // Serial adder
  logic a_bit, b_raw, b_eff, cin, sum_bit, carry_next;

  always_comb begin
    a_bit = 1'b0;
    b_raw = 1'b0;
    case (opcode)
      OpReg, OpImm, OpBranch: begin
        a_bit = rs1_val[counter];
        b_raw = op_b[counter];
      end
      OpAuipc: begin
        a_bit = pc;
        b_raw = imm_u[counter];
      end
      OpJal, OpJalr: begin
        a_bit = pc;
        b_raw = (counter == 5'd2);
      end
      default: ;
    endcase
  end

  assign b_eff      = b_raw ^ is_sub;
  assign cin        = (counter == 5'd0) ? is_sub : carry_q;
  assign sum_bit    = a_bit ^ b_eff ^ cin;
  assign carry_next = (a_bit & b_eff) | (a_bit & cin) | (b_eff & cin);

  // Comparison flags; meaningful on the counter=31 clock where a/b/sum are the sign bits
  logic eq_now, lt, ltu, taken;
  assign eq_now = ((counter == 5'd0) ? 1'b1 : eq_q) & ~sum_bit;
  assign lt     = (a_bit ^ b_raw) ? a_bit : sum_bit;
  assign ltu    = ~carry_next;

  always_comb begin
    case (funct3)
      3'b000:  taken = eq_now;
      3'b001:  taken = ~eq_now;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

  // Shifter: pick the source bit directly by index
  logic [4:0] sh;
  logic [5:0] idx_r;
  logic       sll_bit, srl_bit;
  assign sh      = (opcode == OpImm) ? instr[24:20] : rs2_val[4:0];
  assign idx_r   = {1'b0, counter} + {1'b0, sh};
  assign sll_bit = (counter >= sh) ? rs1_val[counter - sh] : 1'b0;
  assign srl_bit = idx_r[5] ? (alt & rs1_val[31]) : rs1_val[idx_r[4:0]];

  logic alu_bit, res_bit;
  always_comb begin
    case (funct3)
      3'b000:  alu_bit = sum_bit;
      3'b001:  alu_bit = sll_bit;
      3'b100:  alu_bit = rs1_val[counter] ^ op_b[counter];
      3'b101:  alu_bit = srl_bit;
      3'b110:  alu_bit = rs1_val[counter] | op_b[counter];
      3'b111:  alu_bit = rs1_val[counter] & op_b[counter];
      default: alu_bit = 1'b0;  // SLT/SLTU shift zeros, flag inserted at writeback
    endcase
  end

  always_comb begin
    case (opcode)
      OpReg, OpImm:          res_bit = alu_bit;
      OpLui:                 res_bit = imm_u[counter];
      OpAuipc, OpJal, OpJalr: res_bit = sum_bit;
      OpLoad:                res_bit = data_in;
      OpStore:               res_bit = rs2_val[counter];
      default:               res_bit = 1'b0;
    endcase
  end

  logic [31:0] wb_val;
  assign wb_val = is_slt ? {31'd0, funct3[0] ? ltu : lt} : {res_bit, data_out_q[31:1]};

  // Next state
  always_comb begin
    data_out_d = data_out_q;
    carry_d    = carry_q;
    eq_d       = eq_q;
    branch_d   = branch_q;
    if (cycle == 3'd0) begin
      data_out_d = last ? wb_val : {res_bit, data_out_q[31:1]};
      carry_d    = carry_next;
      eq_d       = eq_now;
      if (last) begin
        branch_d = (opcode == OpJal) || (opcode == OpJalr) || ((opcode == OpBranch) && taken);
      end
    end else if (shift_data_out) begin
      data_out_d = {1'b0, data_out_q[31:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      data_out_q <= 32'd0;
      branch_q   <= 1'b0;
      carry_q    <= 1'b0;
      eq_q       <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      branch_q   <= branch_d;
      carry_q    <= carry_d;
      eq_q       <= eq_d;
    end
  end

  // Register file is not reset; entry 0 is never written and never read
  logic rf_we;
  assign rf_we = last && writes_rd && (rd != 5'd0) && !rd[4];

  always_ff @(posedge clk) begin
    if (!rstn && rf_we) begin
      regs[rd[3:0]] <= wb_val;
    end
  end

  assign shift_pc = (cycle == 3'd0);
  assign data_out = data_out_q;
  assign branch   = branch_q;

endmodule

// File: tb/tb_nano_v_core.sv
// Self-checking bench for nano_v_core: directed vector table, hand-written multi-cycle
// sequences, then random instructions against a behavioural model.
module tb_nano_v_core;

  logic        clk;
  logic        rstn;
  logic [30:0] next_instr;
  logic [31:0] instr;
  logic [2:0]  cycle;
  logic [4:0]  counter;
  logic        pc;
  logic        data_in;
  logic        shift_data_out;
  logic        shift_pc;
  logic [31:0] data_out;
  logic        branch;

  nano_v_core dut (
    .clk            (clk),
    .rstn           (rstn),
    .next_instr     (next_instr),
    .instr          (instr),
    .cycle          (cycle),
    .counter        (counter),
    .pc             (pc),
    .data_in        (data_in),
    .shift_data_out (shift_data_out),
    .shift_pc       (shift_pc),
    .data_out       (data_out),
    .branch         (branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_regs [16];

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pcv;
    logic [31:0] din;
    logic        chk_do;
    logic [31:0] exp_do;
    logic        exp_br;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // One execute pass; if abort_at >= 0, rstn is asserted on that counter's clock
  task automatic run_pass(input logic [31:0] ins, input logic [31:0] pcv, input logic [31:0] din,
                          input int abort_at);
    instr      = ins;
    next_instr = 31'($urandom);
    cycle      = 3'd0;
    for (int i = 0; i < 32; i++) begin
      counter        = 5'(i);
      pc             = pcv[i];
      data_in        = din[i];
      shift_data_out = 1'($urandom);
      rstn           = (i == abort_at);
      @(posedge clk);
      #1;
    end
    rstn           = 1'b0;
    cycle          = 3'd1;
    shift_data_out = 1'b0;
  endtask

  task automatic idle(input int n, input logic sh);
    for (int i = 0; i < n; i++) begin
      cycle          = 3'($urandom_range(1, 7));
      counter        = 5'($urandom);
      shift_data_out = sh;
      @(posedge clk);
      #1;
    end
    shift_data_out = 1'b0;
  endtask

  function automatic logic [31:0] rreg(input logic [4:0] idx);
    return (idx[3:0] == 4'd0) ? 32'd0 : m_regs[idx[3:0]];
  endfunction

  // Architectural reference: whole-word arithmetic on the instruction's meaning
  task automatic model_exec(input logic [31:0] ins, input logic [31:0] pcv,
                            input logic [31:0] din, output logic [31:0] res, output logic wr,
                            output logic br, output logic chk_do);
    logic [31:0] a, b, imm_i, imm_u;
    logic [4:0]  sh;
    logic [6:0]  op;
    logic [2:0]  f3;
    op    = ins[6:0];
    f3    = ins[14:12];
    a     = rreg(ins[19:15]);
    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_u = {ins[31:12], 12'd0};
    b     = (op == 7'h33) ? rreg(ins[24:20]) : imm_i;
    sh    = (op == 7'h33) ? b[4:0] : ins[24:20];
    res    = 32'd0;
    wr     = 1'b0;
    br     = 1'b0;
    chk_do = 1'b1;
    case (op)
      7'h33, 7'h13: begin
        wr = 1'b1;
        case (f3)
          3'd0: res = (op == 7'h33 && ins[30]) ? a - b : a + b;
          3'd1: res = a << sh;
          3'd2: res = {31'd0, $signed(a) < $signed(b)};
          3'd3: res = {31'd0, a < b};
          3'd4: res = a ^ b;
          3'd5: res = ins[30] ? $unsigned($signed(a) >>> sh) : a >> sh;
          3'd6: res = a | b;
          default: res = a & b;
        endcase
      end
      7'h37: begin res = imm_u; wr = 1'b1; end
      7'h17: begin res = pcv + imm_u; wr = 1'b1; end
      7'h6F, 7'h67: begin res = pcv + 32'd4; wr = 1'b1; br = 1'b1; end
      7'h03: begin res = din; wr = 1'b1; end
      7'h23: res = rreg(ins[24:20]);
      7'h63: begin
        chk_do = 1'b0;
        b = rreg(ins[24:20]);
        case (f3)
          3'd0: br = (a == b);
          3'd1: br = (a != b);
          3'd4: br = $signed(a) < $signed(b);
          3'd5: br = $signed(a) >= $signed(b);
          3'd6: br = a < b;
          3'd7: br = a >= b;
          default: br = 1'b0;
        endcase
      end
      default: chk_do = 1'b0;
    endcase
  endtask

  function automatic logic [31:0] gen_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] r;
    int          kind;
    rd   = 5'($urandom);
    rs1  = 5'($urandom);
    rs2  = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom);
    f3   = 3'($urandom);
    r    = $urandom;
    kind = $urandom_range(0, 10);
    case (kind)
      0, 1: return {1'b0, ((f3 == 3'd0 || f3 == 3'd5) ? r[0] : 1'b0), 5'd0, rs2, rs1, f3, rd,
                    7'h33};
      2, 3: begin
        if (f3 == 3'd1 || f3 == 3'd5)
          return {1'b0, (f3 == 3'd5) ? r[0] : 1'b0, 5'd0, r[8:4], rs1, f3, rd, 7'h13};
        return {r[11:0], rs1, f3, rd, 7'h13};
      end
      4: return {r[19:0], rd, (r[20] ? 7'h37 : 7'h17)};
      5: return {r[19:0], rd, 7'h6F};
      6: return {r[11:0], rs1, 3'd0, rd, 7'h67};
      7: return {r[6:0], rs2, rs1, ((f3[2:1] == 2'b01) ? 3'd0 : f3), r[11:7], 7'h63};
      8: return {r[11:0], rs1, 3'd2, rd, 7'h03};
      9: return {r[6:0], rs2, rs1, 3'd2, r[11:7], 7'h23};
      default: return {r[24:0], (r[25] ? 7'h0F : 7'h73)};
    endcase
  endfunction

  initial begin
    logic [31:0] res, ins, pcv, din;
    logic        wr, br, cdo;
    int          k;

    rstn = 1'b1; next_instr = '0; instr = '0; cycle = 3'd1; counter = '0;
    pc = 1'b0; data_in = 1'b0; shift_data_out = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    chk("reset_data_out", data_out, 32'h0);
    chk("reset_branch", {31'd0, branch}, 32'h0);
    chk("shift_pc_idle", {31'd0, shift_pc}, 32'h0);
    cycle = 3'd0;
    #1;
    chk("shift_pc_exec", {31'd0, shift_pc}, 32'h1);

    // ins, pc, data_in, check data_out, expected data_out, expected branch
    vecs[0]  = '{32'h00500093, 32'h0, 32'h0, 1'b1, 32'h00000005, 1'b0}; // ADDI x1,x0,5
    vecs[1]  = '{32'h00108133, 32'h0, 32'h0, 1'b1, 32'h0000000A, 1'b0}; // ADD x2,x1,x1
    vecs[2]  = '{32'h401001B3, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFB, 1'b0}; // SUB x3,x0,x1
    vecs[3]  = '{32'h12345237, 32'h0, 32'h0, 1'b1, 32'h12345000, 1'b0}; // LUI x4
    vecs[4]  = '{32'h4011D293, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFD, 1'b0}; // SRAI x5,x3,1
    vecs[5]  = '{32'h0020B333, 32'h0, 32'h0, 1'b1, 32'h00000001, 1'b0}; // SLTU x6,x1,x2
    vecs[6]  = '{32'h00108463, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1};        // BEQ x1,x1
    vecs[7]  = '{32'h00109463, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0};        // BNE x1,x1
    vecs[8]  = '{32'h0011C463, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1};        // BLT x3,x1
    vecs[9]  = '{32'h0011E463, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0};        // BLTU x3,x1
    vecs[10] = '{32'h00202023, 32'h0, 32'h0, 1'b1, 32'h0000000A, 1'b0}; // SW x2,0(x0)
    vecs[11] = '{32'h00002383, 32'h0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b0}; // LW x7
    vecs[12] = '{32'h00702023, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0}; // SW x7
    vecs[13] = '{32'h00700013, 32'h0, 32'h0, 1'b1, 32'h00000007, 1'b0}; // ADDI x0,x0,7
    vecs[14] = '{32'h00002023, 32'h0, 32'h0, 1'b1, 32'h00000000, 1'b0}; // SW x0
    vecs[15] = '{32'h0000046F, 32'h100, 32'h0, 1'b1, 32'h00000104, 1'b1}; // JAL x8
    vecs[16] = '{32'h00802023, 32'h0, 32'h0, 1'b1, 32'h00000104, 1'b0}; // SW x8
    vecs[17] = '{32'h00302023, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFB, 1'b0}; // SW x3
    vecs[18] = '{32'h00102023, 32'h0, 32'h0, 1'b1, 32'h00000005, 1'b0}; // SW x1

    for (int v = 0; v < 19; v++) begin
      run_pass(vecs[v].ins, vecs[v].pcv, vecs[v].din, -1);
      if (vecs[v].chk_do) chk($sformatf("vec%0d_data_out", v), data_out, vecs[v].exp_do);
      chk($sformatf("vec%0d_branch", v), {31'd0, branch}, {31'd0, vecs[v].exp_br});
      idle(1, 1'b0);
    end

    // Idle shifting with branch held high: JAL x11 from pc 0xEFFFFFFC gives 0xF0000000
    run_pass(32'h000005EF, 32'hEFFFFFFC, 32'h0, -1);
    chk("jal_f0_data_out", data_out, 32'hF0000000);
    idle(4, 1'b1);
    chk("idle_shift4", data_out, 32'h0F000000);
    chk("idle_branch_held", {31'd0, branch}, 32'h1);
    idle(3, 1'b0);
    chk("idle_hold", data_out, 32'h0F000000);
    chk("idle_branch_held2", {31'd0, branch}, 32'h1);

    // Reset on the counter=31 clock aborts the write
    run_pass(32'h05500493, 32'h0, 32'h0, -1);  // ADDI x9,x0,0x55
    run_pass(32'h7FF00493, 32'h0, 32'h0, 31);  // ADDI x9,x0,0x7FF, aborted
    chk("abort_data_out", data_out, 32'h0);
    chk("abort_branch", {31'd0, branch}, 32'h0);
    run_pass(32'h00902023, 32'h0, 32'h0, -1);  // SW x9
    chk("abort_no_write", data_out, 32'h00000055);

    // Random phase: seed every register by LOAD, then random instructions
    for (int r = 1; r < 16; r++) begin
      din = $urandom;
      ins = {12'($urandom), 5'($urandom), 3'd2, 5'(r), 7'h03};
      run_pass(ins, $urandom, din, -1);
      m_regs[r] = din;
    end
    for (int it = 0; it < 300; it++) begin
      ins = gen_instr();
      pcv = $urandom;
      din = $urandom;
      model_exec(ins, pcv, din, res, wr, br, cdo);
      run_pass(ins, pcv, din, -1);
      if (cdo) chk($sformatf("rnd%0d_%08h_data_out", it, ins), data_out, res);
      chk($sformatf("rnd%0d_%08h_branch", it, ins), {31'd0, branch}, {31'd0, br});
      if (wr && ins[11:7] != 5'd0 && !ins[11]) m_regs[ins[10:7]] = res;
      k = $urandom_range(0, 3);
      if (k > 0) begin
        idle(k, 1'b1);
        if (cdo) chk($sformatf("rnd%0d_idle_shift", it), data_out, res >> k);
        chk($sformatf("rnd%0d_idle_branch", it), {31'd0, branch}, {31'd0, br});
      end
    end
    for (int r = 1; r < 16; r++) begin
      run_pass({7'd0, 5'(r), 5'd0, 3'd2, 5'd0, 7'h23}, 32'h0, 32'h0, -1);
      chk($sformatf("final_x%0d", r), data_out, m_regs[r]);
    end

    // Reset clears a nonzero data_out and a set branch
    run_pass(32'h0000046F, 32'h200, 32'h0, -1);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    chk("reset2_data_out", data_out, 32'h0);
    chk("reset2_branch", {31'd0, branch}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
